// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - core-side issue sequencer for the private FPU wrapper
//
// Purpose
//    Accepts one floating-point request at a time over a valid/ready handshake.
//    The operands are registered and driven to the FPU. The FPU enable is held
//    until the FPU reports a result. That result is buffered with its
//    destination tag until the writeback consumer takes it. A flush drains the
//    FPU's internal cycle counter, so the next operation starts aligned.
//
// Optional feature
//    FPU_ISSUE_TIMEOUT_EN : when defined, a watchdog ends a BUSY or DRAIN phase
//                           after TIMEOUT non-stalled cycles with no fpu_valid_i.
//                           In BUSY it writes back a canonical NaN and sets
//                           wb_err_o. When undefined, wb_err_o is 0 and the
//                           controller waits indefinitely.
//
// Ports
//    clk, rst          clock, synchronous active-high reset
//    req_*             request handshake, operands, rounding mode, operator, tag
//    stall_i           core pipeline stall (forwarded to the FPU while BUSY)
//    flush_i           kill the in-flight request
//    fpu_*_o           enable, registered operands/rm/cmd and stall to the FPU
//    fpu_result_i      FPU result
//    fpu_valid_i       FPU result valid
//    wb_*              buffered result, tag and error flag for register writeback

module fpu_issue_ctrl #(
   parameter int unsigned C_OP    = 32,
   parameter int unsigned C_RM    = 3,
   parameter int unsigned C_CMD   = 4,
   parameter int unsigned TAG_W   = 5,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             rst,
   // request side
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [C_OP-1:0]  req_op_a_i,
   input  logic [C_OP-1:0]  req_op_b_i,
   input  logic [C_RM-1:0]  req_rm_i,
   input  logic [C_CMD-1:0] req_cmd_i,
   input  logic [TAG_W-1:0] req_tag_i,
   // pipeline control
   input  logic             stall_i,
   input  logic             flush_i,
   // FPU side
   output logic             fpu_enable_o,
   output logic [C_OP-1:0]  fpu_op_a_o,
   output logic [C_OP-1:0]  fpu_op_b_o,
   output logic [C_RM-1:0]  fpu_rm_o,
   output logic [C_CMD-1:0] fpu_cmd_o,
   output logic             fpu_stall_o,
   input  logic [C_OP-1:0]  fpu_result_i,
   input  logic             fpu_valid_i,
   // writeback side
   output logic             wb_valid_o,
   input  logic             wb_ready_i,
   output logic [C_OP-1:0]  wb_result_o,
   output logic [TAG_W-1:0] wb_tag_o,
   output logic             wb_err_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_DRAIN = 2'd2,
      S_WB    = 2'd3
   } state_t;

   localparam logic [C_OP-1:0] QNAN = C_OP'(32'h7FC0_0000);

   state_t           state;
   logic [TAG_W-1:0] tag_q;      // tag of the op currently in the FPU
   logic             can_take;   // a new request may be taken this cycle
   logic             accept;     // request handshake completes this cycle
   logic             fpu_done;   // FPU result is consumed this cycle
   logic             wd_fire;    // watchdog expiry this cycle

   // A new request can enter from IDLE, or from WB in the same cycle the
   // buffered result is consumed. That gives back-to-back issue with exactly
   // one enable-low cycle between ops. The reset term keeps the handshake
   // outputs low while rst is asserted.
   assign can_take    = ~rst & ((state == S_IDLE) | ((state == S_WB) & wb_ready_i));
   assign req_ready_o = can_take;
   assign accept      = can_take & req_valid_i;

   // The stall only reaches the FPU while BUSY. In DRAIN the FPU must keep
   // counting so its internal counter returns to zero.
   assign fpu_stall_o = ~rst & (state == S_BUSY) & stall_i;

   // A result presented while stalled stays on the FPU outputs, so it is only
   // taken on a non-stalled cycle.
   assign fpu_done    = fpu_valid_i & ~stall_i;

`ifdef FPU_ISSUE_TIMEOUT_EN
   localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] wd_cnt;
   logic            wd_tick;

   // Count cycles in which the FPU should have made progress and did not.
   // DRAIN carries on from the BUSY count, so a flushed op stays within
   // one overall budget.
   assign wd_tick = ~fpu_valid_i &
                    (((state == S_BUSY) & ~stall_i) | (state == S_DRAIN));
   assign wd_fire = wd_tick & (wd_cnt == WD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (accept) begin
         wd_cnt <= '0;
      end else if (wd_tick & ~wd_fire) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;

   assign wd_fire            = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         tag_q        <= '0;
         fpu_enable_o <= 1'b0;
         fpu_op_a_o   <= '0;
         fpu_op_b_o   <= '0;
         fpu_rm_o     <= '0;
         fpu_cmd_o    <= '0;
         wb_valid_o   <= 1'b0;
         wb_result_o  <= '0;
         wb_tag_o     <= '0;
         wb_err_o     <= 1'b0;
      end else begin
         // The operand registers change only on a request capture. They
         // therefore stay stable for the whole FPU operation.
         if (accept) begin
            fpu_op_a_o <= req_op_a_i;
            fpu_op_b_o <= req_op_b_i;
            fpu_rm_o   <= req_rm_i;
            fpu_cmd_o  <= req_cmd_i;
            tag_q      <= req_tag_i;
         end

         case (state)
            S_IDLE: begin
               if (accept) begin
                  state        <= S_BUSY;
                  fpu_enable_o <= 1'b1;
               end
            end

            S_BUSY: begin
               // A flush wins over a simultaneous result. The enable stays
               // high through DRAIN.
               if (flush_i) begin
                  state <= S_DRAIN;
               end else if (fpu_done) begin
                  state        <= S_WB;
                  fpu_enable_o <= 1'b0;
                  wb_valid_o   <= 1'b1;
                  wb_result_o  <= fpu_result_i;
                  wb_tag_o     <= tag_q;
                  wb_err_o     <= 1'b0;
               end else if (wd_fire) begin
                  state        <= S_WB;
                  fpu_enable_o <= 1'b0;
                  wb_valid_o   <= 1'b1;
                  wb_result_o  <= QNAN;
                  wb_tag_o     <= tag_q;
                  wb_err_o     <= 1'b1;
               end
            end

            S_DRAIN: begin
               // The killed op's result is discarded. Further flushes have
               // nothing left to cancel.
               if (fpu_valid_i | wd_fire) begin
                  state        <= S_IDLE;
                  fpu_enable_o <= 1'b0;
               end
            end

            S_WB: begin
               // The result is already complete, so flush_i has no effect here.
               if (wb_ready_i) begin
                  wb_valid_o <= 1'b0;
                  if (req_valid_i) begin
                     state        <= S_BUSY;
                     fpu_enable_o <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end

            default: begin
               state        <= S_IDLE;
               fpu_enable_o <= 1'b0;
               wb_valid_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule
